apb_mst_bridge: RTL and testbench
=================================

// Module: apb_mst_bridge
// PURPOSE
// - APB initiator: turns a single-outstanding valid/ready request channel into APB SETUP/ACCESS transfers.
// - Returns the slave's read data and error on a valid/ready response channel.
// - Sits between a local controller (debug/DMA/boot sequencer) and the APB bridge input that feeds APB responders such as the PRCI.
// PARAMETERS
// - TMO_CYCLES  1024  ACCESS-phase wait limit in cycles; 10-bit counter; legal range 2..1023, 1024 stored as 0 = 1024.
// PORTS
// - i_clk          in   1    Clock.
// - i_pwrreset     in   1    Reset: asynchronous, active-high.
// - i_req_valid    in   1    Request valid.
// - o_req_ready    out  1    Request accepted when valid&&ready.
// - i_req_addr     in   32   Byte address; [1:0] ignored and driven 0 on paddr.
// - i_req_write    in   1    1=write, 0=read.
// - i_req_wdata    in   32   Write data.
// - i_req_wstrb    in   4    Write byte strobes; forced to 0 on reads.
// - o_resp_valid   out  1    Response valid.
// - i_resp_ready   in   1    Response consumed when valid&&ready.
// - o_resp_rdata   out  32   Read data; 0 for writes and errors.
// - o_resp_err     out  1    1 = pslverr from slave, or timeout.
// - o_apbo         out  apb_in_type   paddr/pprot/pselx/penable/pwrite/pwdata/pstrb to the slave.
// - i_apbi         in   apb_out_type  prdata/pready/pslverr from the slave.
// BEHAVIOUR
// - Reset values, async on i_pwrreset:
//   - state=IDLE; o_req_ready=1; o_resp_valid=0; o_resp_rdata=0; o_resp_err=0.
//   - All o_apbo fields 0; pprot fixed 3'b000.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
//   - IDLE: o_req_ready=1. On valid&&ready, latch addr/write/wdata/wstrb and go to SETUP.
//   - SETUP (1 cycle): pselx=1, penable=0, address and control stable; next state ACCESS.
//   - ACCESS: pselx=1, penable=1. On pready=1, capture prdata (reads only) and pslverr, then go to RESP.
//   - RESP: o_resp_valid=1, pselx=0, penable=0. Hold outputs until i_resp_ready=1, then go to IDLE.
// - Outputs are registered. Minimum latency: accept at edge N, SETUP N+1, ACCESS N+2, o_resp_valid at N+3 with zero-wait slave.
// - o_req_ready=0 outside IDLE; a single transaction is outstanding.
// - The request is never re-accepted while in RESP, even if resp and req handshakes coincide.
// - Back-to-back throughput: 1 transfer per 4 cycles, given resp_ready=1.
// - APB rule: paddr/pwrite/pwdata/pstrb stay constant from SETUP through the last ACCESS cycle.
// - pslverr is sampled only with pready=1; prdata is ignored on writes.
// - pready=1 during SETUP is ignored.
// - Reset mid-transfer: the bus returns to idle immediately (async), no response is produced, the request is lost.
// CONFIGURATION
// - APB_MST_TIMEOUT_EN defined:
//   - ACCESS counter cnt starts at 0 on entering ACCESS and increments per cycle without pready.
//   - At cnt==TMO_CYCLES-1 with pready=0: drop pselx/penable, go to RESP with err=1, rdata=0.
//   - pready on the expiry cycle wins (normal completion).
// - APB_MST_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely.
// TESTING
// - Read 0x1000_0004, slave pready=1 at first ACCESS, prdata=0x3 -> resp at cycle 3, rdata=0x3, err=0, exactly 1 SETUP + 1 ACCESS.
// - Write 0x1000_0000, wdata=0xDEADBEEF, wstrb=0xF, slave waits 5 cycles -> paddr/pwdata stable all 6 ACCESS cycles, resp err=0, rdata=0.
// - Read with pslverr=1 at pready -> o_resp_err=1, o_resp_rdata=0.
// - resp_ready held 0 for 10 cycles with i_req_valid=1 -> o_resp_valid held, o_req_ready=0, no new psel until handshake.
// - APB_MST_TIMEOUT_EN, TMO_CYCLES=16, pready stuck 0 -> psel drops after 16 ACCESS cycles, err=1. Undefined: psel still 1 after 100 cycles.
// - i_pwrreset pulsed in ACCESS -> o_apbo all 0 same cycle, no o_resp_valid, next request completes normally.

Source files
------------

// File: rtl/apb_mst_bridge.sv
// ---------------------------------------------------------------------------
// apb_mst_bridge : valid/ready request -> APB SETUP/ACCESS initiator.
// Optional ACCESS timeout when APB_MST_TIMEOUT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_mst_bridge_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;
endpackage

module apb_mst_bridge
  import apb_mst_bridge_pkg::*;
#(
  parameter int TMO_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_pwrreset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output apb_in_type  o_apbo,
  input  apb_out_type i_apbi
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  generate
    if (TMO_CYCLES < 2 || TMO_CYCLES > 1024) begin : g_tmo_range_chk
      $error("apb_mst_bridge: TMO_CYCLES must be in 2..1024");
    end
  endgenerate

  state_t r_state;

`ifdef APB_MST_TIMEOUT_EN
  // 1024 wraps to 0 in 10 bits, so the last-cycle compare value is still 1023.
  localparam logic [9:0] c_tmo_last = 10'(TMO_CYCLES - 1);
  logic [9:0] r_cnt;
`endif

  always_ff @(posedge i_clk or posedge i_pwrreset) begin
    if (i_pwrreset) begin
      r_state      <= ST_IDLE;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
      o_apbo       <= '0;
`ifdef APB_MST_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            o_apbo.paddr   <= i_req_addr & ~32'h3;
            o_apbo.pwrite  <= i_req_write;
            o_apbo.pwdata  <= i_req_wdata;
            o_apbo.pstrb   <= i_req_write ? i_req_wstrb : 4'h0;
            o_apbo.pselx   <= 1'b1;
            o_apbo.penable <= 1'b0;
            o_req_ready    <= 1'b0;
            r_state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          o_apbo.penable <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
          r_cnt          <= '0;
`endif
          r_state        <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (i_apbi.pready) begin
            o_resp_rdata   <= (!o_apbo.pwrite && !i_apbi.pslverr) ? i_apbi.prdata : 32'h0;
            o_resp_err     <= i_apbi.pslverr;
            o_resp_valid   <= 1'b1;
            o_apbo.pselx   <= 1'b0;
            o_apbo.penable <= 1'b0;
            r_state        <= ST_RESP;
          end
`ifdef APB_MST_TIMEOUT_EN
          else if (r_cnt == c_tmo_last) begin
            o_resp_rdata   <= 32'h0;
            o_resp_err     <= 1'b1;
            o_resp_valid   <= 1'b1;
            o_apbo.pselx   <= 1'b0;
            o_apbo.penable <= 1'b0;
            r_state        <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
`endif
        end
        ST_RESP: begin
          // Ready rises only after the handshake, so a request can't be taken here.
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
            o_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_mst_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_mst_bridge : vector table, random transfers and corner sequences.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_apb_mst_bridge;
  import apb_mst_bridge_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  apb_in_type  apbo;
  apb_out_type apbi;

  logic [31:0] s_prdata;
  logic        s_slverr, s_setup_rdy, w_pready;
  int          s_wait;
  int          acc_cnt;

  logic [71:0] exp_bus;
  int          setup_n, access_n;
  int          n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  apb_mst_bridge #(.TMO_CYCLES(TMO)) dut (
    .i_clk(clk), .i_pwrreset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_write(req_write),
    .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_apbo(apbo), .i_apbi(apbi)
  );

  // Slave: answers on the (s_wait+1)-th ACCESS cycle; optionally raises pready in SETUP.
  assign w_pready = apbo.pselx & (apbo.penable ? (acc_cnt >= s_wait) : s_setup_rdy);
  assign apbi = '{prdata: s_prdata, pready: w_pready, pslverr: s_slverr};

  always @(posedge clk or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else if (apbo.pselx && apbo.penable && !w_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && apbo.pselx) begin
      if (apbo.penable) access_n++;
      else setup_n++;
      chk("apb_bus_stable", {apbo.paddr, apbo.pwrite, apbo.pwdata, apbo.pstrb, apbo.pprot}, exp_bus);
    end
  end

  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int wait_n, input logic [31:0] prdata,
                        input logic slverr, input logic setup_rdy, input int hold,
                        input logic hold_req, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_acc, input int exp_lat);
    int lat;
    int bad;
    @(posedge clk); #1;
    s_wait = wait_n; s_prdata = prdata; s_slverr = slverr; s_setup_rdy = setup_rdy;
    exp_bus = {addr & ~32'h3, wr, wdata, (wr ? wstrb : 4'h0), 3'b000};
    setup_n = 0; access_n = 0;
    chk("req_ready_idle", {31'h0, req_ready}, 80'h1);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_latency", 80'(lat), 80'(exp_lat));
    bad = 0;
    req_valid = hold_req;
    for (int i = 0; i < hold; i++) begin
      if (!resp_valid || req_ready || apbo.pselx) bad++;
      @(posedge clk); #1;
    end
    chk("resp_hold", 80'(bad), 80'h0);
    chk("resp_rdata", 80'(resp_rdata), 80'(exp_rdata));
    chk("resp_err", 80'(resp_err), 80'(exp_err));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("resp_done", {77'h0, resp_valid, req_ready, apbo.pselx}, 80'b010);
    chk("setup_cycles", 80'(setup_n), 80'h1);
    chk("access_cycles", 80'(access_n), 80'(exp_acc));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_n;
    logic [31:0] prdata;
    logic        slverr;
    logic        setup_rdy;
    int          hold;
    logic        hold_req;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          bad;
    logic [31:0] a, wd, pd, er;
    logic        w, se;
    logic [3:0]  ws;
    int          wn, hd;

    vecs[0] = '{32'h1000_0004, 1'b0, 32'h0,        4'h0, 0, 32'h3,        1'b0, 1'b0, 0,  1'b0, 32'h3,        1'b0};
    vecs[1] = '{32'h1000_0000, 1'b1, 32'hDEADBEEF, 4'hF, 5, 32'h1234_5678, 1'b0, 1'b0, 0,  1'b0, 32'h0,        1'b0};
    vecs[2] = '{32'h1000_0008, 1'b0, 32'h0,        4'h0, 2, 32'hAAAA_5555, 1'b1, 1'b0, 0,  1'b0, 32'h0,        1'b1};
    vecs[3] = '{32'h1000_0013, 1'b0, 32'hCAFE,     4'hF, 1, 32'h0BAD_F00D, 1'b0, 1'b1, 0,  1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{32'h2000_0100, 1'b1, 32'h0102_0304, 4'h5, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0,  1'b0, 32'h0,        1'b1};
    vecs[5] = '{32'h3000_0000, 1'b0, 32'h0,        4'h0, 0, 32'h55,       1'b0, 1'b0, 10, 1'b1, 32'h55,       1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_wstrb = '0; resp_ready = 1'b0; s_prdata = '0; s_slverr = 1'b0; s_setup_rdy = 1'b0;
    s_wait = 0; exp_bus = '0; setup_n = 0; access_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, resp_valid, resp_rdata, resp_err}, {1'b1, 1'b0, 32'h0, 1'b0});
    chk("reset_apbo", 80'(apbo), 80'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].wstrb, vecs[i].wait_n,
             vecs[i].prdata, vecs[i].slverr, vecs[i].setup_rdy, vecs[i].hold, vecs[i].hold_req,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].wait_n + 1, vecs[i].wait_n + 3);

    // Random transfers against the protocol-level model.
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;  w = 1'($urandom_range(0, 1)); wd = $urandom; ws = 4'($urandom);
      wn = $urandom_range(0, 4); pd = $urandom; se = ($urandom_range(0, 7) == 0);
      hd = $urandom_range(0, 3);
      er = (!w && !se) ? pd : 32'h0;
      do_txn(a, w, wd, ws, wn, pd, se, 1'($urandom_range(0, 1)), hd, 1'($urandom_range(0, 1)),
             er, se, wn + 1, wn + 3);
    end

`ifdef APB_MST_TIMEOUT_EN
    // Stuck slave: TMO ACCESS cycles then error; pready on the last allowed cycle still wins.
    do_txn(32'h4000_0000, 1'b0, 32'h0, 4'h0, 100000, 32'h77, 1'b0, 1'b0, 0, 1'b0,
           32'h0, 1'b1, TMO, TMO + 2);
    do_txn(32'h4000_0004, 1'b0, 32'h0, 4'h0, TMO - 1, 32'h78, 1'b0, 1'b0, 0, 1'b0,
           32'h78, 1'b0, TMO, TMO + 2);
`endif

    // Stuck slave, then reset during ACCESS.
    @(posedge clk); #1;
    s_wait = 100000; s_setup_rdy = 1'b0; s_slverr = 1'b0; s_prdata = 32'h99;
    exp_bus = {32'h2000_0008, 1'b0, 32'h0, 4'h0, 3'b000};
    req_valid = 1'b1; req_addr = 32'h2000_0008; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifndef APB_MST_TIMEOUT_EN
    repeat (101) @(posedge clk);
    #1;
    chk("no_timeout_wait", {77'h0, apbo.pselx, apbo.penable, resp_valid}, 80'b110);
`else
    repeat (5) @(posedge clk);
    #1;
`endif
    #2 rst = 1'b1;
    #1;
    chk("reset_async_apbo", 80'(apbo), 80'h0);
    chk("reset_async_resp", {78'h0, resp_valid, req_ready}, 80'b01);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid || apbo.pselx) bad++;
      @(posedge clk); #1;
    end
    chk("reset_no_resp", 80'(bad), 80'h0);
    do_txn(32'h1000_0020, 1'b1, 32'h1111_2222, 4'h3, 1, 32'h0, 1'b0, 1'b0, 1, 1'b0,
           32'h0, 1'b0, 2, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
